instr_fetch_decode: RTL and testbench

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

---
 rtl/instr_fetch_decode.sv | 211 +++++++++++++++++++++
 tb/tb_instr_fetch_decode.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// instr_fetch_decode
//   Fetches one 16-bit instruction word from instruction memory on request
//   from the control FSM and turns it into the FSM's 27-bit opcode input
//   ({RX, RY, one-hot class}) plus an 8-bit immediate.
//
//   Optional feature (compile-time macro IFD_TIMEOUT_EN):
//     When IFD_TIMEOUT_EN is defined, a fetch that waits TIMEOUT_CYCLES
//     cycles without imem_ack is abandoned.  The abandoned fetch raises the
//     sticky fetch_error flag and presents a NOOP as a valid opcode.
//     When IFD_TIMEOUT_EN is not defined, the fetch waits forever and
//     fetch_error is tied low.
//
// Ports
//   clock, reset     rising-edge clock, asynchronous active-high reset
//   fetch_start      one-cycle fetch request, samples pc_in
//   flush            abandon fetch / invalidate opcode (with fetch_start: redirect)
//   pc_in            instruction address
//   imem_req/addr    registered memory read request and address
//   imem_ack/data    memory response strobe and instruction word
//   opcode_out       [26:25] RX, [24:23] RY, [22:0] one-hot instruction class
//   imm_out          immediate field of the decoded instruction
//   opcode_valid     opcode_out/imm_out hold a decoded instruction
//   busy             fetch or decode in progress
//   fetch_error      sticky timeout flag
// ---------------------------------------------------------------------------
module instr_fetch_decode #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        flush,
    input  logic [5:0]  pc_in,
    output logic        imem_req,
    output logic [5:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [26:0] opcode_out,
    output logic [7:0]  imm_out,
    output logic        opcode_valid,
    output logic        busy,
    output logic        fetch_error
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DEC   = 2'd2,
        S_VALID = 2'd3
    } state_t;

    // NOOP class with RX = RY = 0; also the reset and timeout value
    localparam logic [26:0] OPC_NOOP = 27'h0000001;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [5:0]  addr_q, addr_d;
    logic [15:0] ir_q, ir_d;
    logic [26:0] opc_q, opc_d;
    logic [7:0]  imm_q, imm_d;
    logic        vld_q, vld_d;
    logic        start_fetch;

    // Instruction class decode: one bit of [22:0] per instruction
    function automatic logic [22:0] decode_class(input logic [15:0] ir);
        logic [22:0] cls;
        cls = '0;
        case (ir[15:12])
            4'h0: cls[0]  = 1'b1;
            4'h1: cls[1 + 32'(ir[9:8])] = 1'b1;
            4'h2: cls[5]  = 1'b1;
            4'h3: cls[6]  = 1'b1;
            4'h4: cls[7]  = 1'b1;
            4'h5: cls[8]  = 1'b1;
            4'h6: cls[9]  = 1'b1;
            4'h7: cls[10] = 1'b1;
            4'h8: cls[11] = 1'b1;
            4'h9: cls[12] = 1'b1;
            4'hA: cls[13] = 1'b1;
            4'hB: cls[14] = 1'b1;
            4'hC: cls[15 + 32'(ir[8])] = 1'b1;
            4'hD: cls[17] = 1'b1;
            4'hE: cls[18] = 1'b1;
            default: cls[19 + 32'(ir[9:8])] = 1'b1;
        endcase
        return cls;
    endfunction

`ifdef IFD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;

    assign timeout = (state_q == S_REQ) && !imem_ack && !flush
                     && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Main next-state logic. flush has priority over everything; flush
    // together with fetch_start is a branch redirect into a fresh fetch.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        opc_d       = opc_q;
        imm_d       = imm_q;
        vld_d       = vld_q;
        start_fetch = 1'b0;

        if (flush) begin
            start_fetch = fetch_start;
            state_d     = fetch_start ? S_REQ : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_VALID: begin
                    if (fetch_start) begin
                        start_fetch = 1'b1;
                        state_d     = S_REQ;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        ir_d    = imem_data;
                        req_d   = 1'b0;
                        state_d = S_DEC;
                    end
`ifdef IFD_TIMEOUT_EN
                    else if (timeout) begin
                        req_d   = 1'b0;
                        opc_d   = OPC_NOOP;
                        imm_d   = '0;
                        vld_d   = 1'b1;
                        state_d = S_VALID;
                    end
`endif
                end
                S_DEC: begin
                    opc_d   = {ir_q[11:10], ir_q[9:8], decode_class(ir_q)};
                    imm_d   = ir_q[7:0];
                    vld_d   = 1'b1;
                    state_d = S_VALID;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (flush && !fetch_start) begin
            req_d = 1'b0;
            vld_d = 1'b0;
        end
        if (start_fetch) begin
            req_d  = 1'b1;
            addr_d = pc_in;
            vld_d  = 1'b0;
        end
    end

`ifdef IFD_TIMEOUT_EN
    // Counts cycles spent waiting in REQ; restarts on every new fetch
    always_comb begin
        cnt_d = '0;
        if (state_q == S_REQ && state_d == S_REQ && !start_fetch)
            cnt_d = cnt_q + CNT_W'(1);
        err_d = err_q | timeout;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_error = err_q;
`else
    assign fetch_error = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ir_q    <= '0;
            opc_q   <= OPC_NOOP;
            imm_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            opc_q   <= opc_d;
            imm_q   <= imm_d;
            vld_q   <= vld_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign opcode_out   = opc_q;
    assign imm_out      = imm_q;
    assign opcode_valid = vld_q;
    assign busy         = (state_q == S_REQ) || (state_q == S_DEC);

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        flush;
    logic [5:0]  pc_in;
    logic        imem_req;
    logic [5:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [26:0] opcode_out;
    logic [7:0]  imm_out;
    logic        opcode_valid;
    logic        busy;
    logic        fetch_error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [26:0] exp_opc;
    logic [7:0]  exp_imm;
    logic        exp_err;

    instr_fetch_decode #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .fetch_start(fetch_start), .flush(flush),
        .pc_in(pc_in), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .opcode_out(opcode_out),
        .imm_out(imm_out), .opcode_valid(opcode_valid), .busy(busy),
        .fetch_error(fetch_error)
    );

    always #5 clock = ~clock;

    // Reference decode: class index from the instruction table, computed arithmetically
    function automatic logic [26:0] model_opc(input logic [15:0] d);
        int op, sub, idx;
        logic [22:0] one;
        op  = int'(d[15:12]);
        sub = int'(d[9:8]);
        if (op == 0)       idx = 0;
        else if (op == 1)  idx = 1 + sub;
        else if (op == 2)  idx = 5;
        else if (op == 3)  idx = 6;
        else if (op <= 11) idx = op + 3;
        else if (op == 12) idx = 15 + (sub % 2);
        else if (op == 13) idx = 17;
        else if (op == 14) idx = 18;
        else               idx = 19 + sub;
        one = 23'd1 << idx;
        return {d[11:10], d[9:8], one};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_start = 0; flush = 0; pc_in = 0; imem_ack = 0; imem_data = 0;
        exp_opc = 27'h0000001; exp_imm = 0; exp_err = 0;
        tick(); tick();
        n_tests++;
        if ({imem_req, imem_addr, opcode_out, imm_out, opcode_valid, busy, fetch_error}
            !== {1'b0, 6'd0, 27'h0000001, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: req=%b addr=%h opc=%h imm=%h vld=%b busy=%b err=%b", imem_req, imem_addr, opcode_out, imm_out, opcode_valid, busy, fetch_error);
        end
        #2 reset = 1'b0;
        tick();
        n_tests++;
        if ({imem_req, opcode_valid, busy, opcode_out} !== {1'b0, 1'b0, 1'b0, 27'h0000001}) begin
            n_fail++;
            $display("FAIL reset_release: req=%b vld=%b busy=%b opc=%h", imem_req, opcode_valid, busy, opcode_out);
        end
    endtask

    // One complete fetch; a spurious fetch_start is thrown in while waiting
    task automatic do_fetch(input logic [5:0] pc, input logic [15:0] data, input int delay);
        fetch_start = 1; pc_in = pc;
        tick();
        fetch_start = 0;
        n_tests++;
        if ({imem_req, imem_addr, busy, opcode_valid} !== {1'b1, pc, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_req: req=%b addr=%h busy=%b vld=%b want 1 %h 1 0", imem_req, imem_addr, busy, opcode_valid, pc);
        end
        for (int i = 0; i < delay; i++) begin
            if (i == 0) begin fetch_start = 1; pc_in = ~pc; end
            tick();
            fetch_start = 0;
            n_tests++;
            if ({imem_req, imem_addr, opcode_valid} !== {1'b1, pc, 1'b0}) begin
                n_fail++;
                $display("FAIL fetch_wait: req=%b addr=%h vld=%b want 1 %h 0", imem_req, imem_addr, opcode_valid, pc);
            end
        end
        imem_ack = 1; imem_data = data;
        tick();
        imem_ack = 0; imem_data = 16'($urandom);
        n_tests++;
        if ({imem_req, opcode_valid, busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL fetch_dec: req=%b vld=%b busy=%b want 0 0 1", imem_req, opcode_valid, busy);
        end
        tick();
        exp_opc = model_opc(data);
        exp_imm = data[7:0];
        n_tests++;
        if ({opcode_valid, busy, opcode_out, imm_out, fetch_error} !== {1'b1, 1'b0, exp_opc, exp_imm, exp_err}
            || $countones(opcode_out[22:0]) != 1) begin
            n_fail++;
            $display("FAIL fetch_result data=%h: vld=%b busy=%b opc=%h imm=%h err=%b want 1 0 %h %h %b", data, opcode_valid, busy, opcode_out, imm_out, fetch_error, exp_opc, exp_imm, exp_err);
        end
    endtask

    task automatic test_spec_vectors();
        do_fetch(6'd5, 16'h4600, 3);
        n_tests++;
        if ({opcode_out, imm_out} !== {27'h3000080, 8'h00}) begin
            n_fail++;
            $display("FAIL vec_4600: opc=%h imm=%h want 3000080 00", opcode_out, imm_out);
        end
        do_fetch(6'd6, 16'hF3F0, 1);
        n_tests++;
        if ({opcode_out, imm_out} !== {27'h1C00000, 8'hF0}) begin
            n_fail++;
            $display("FAIL vec_F3F0: opc=%h imm=%h want 1C00000 F0", opcode_out, imm_out);
        end
        do_fetch(6'd7, 16'hCD00, 0);
        n_tests++;
        if (opcode_out !== 27'h6810000) begin
            n_fail++;
            $display("FAIL vec_CD00: opc=%h want 6810000", opcode_out);
        end
    endtask

    task automatic test_sweep();
        for (int op = 0; op < 16; op++)
            for (int sub = 0; sub < 4; sub++)
                do_fetch(6'($urandom), {4'(op), 2'($urandom), 2'(sub), 8'($urandom)}, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            do_fetch(6'($urandom), 16'($urandom), int'($urandom_range(0, 6)));
    endtask

    task automatic test_ignore();
        // ack while VALID must not disturb the held result
        do_fetch(6'd12, 16'h2A55, 1);
        imem_ack = 1; imem_data = 16'hE0FF;
        tick(); tick();
        imem_ack = 0;
        n_tests++;
        if ({opcode_valid, busy, imem_req, opcode_out, imm_out} !== {3'b100, exp_opc, exp_imm}) begin
            n_fail++;
            $display("FAIL ack_in_valid: vld=%b busy=%b req=%b opc=%h imm=%h want 1 0 0 %h %h", opcode_valid, busy, imem_req, opcode_out, imm_out, exp_opc, exp_imm);
        end
    endtask

    task automatic test_flush();
        logic [26:0] held_opc;
        // flush alone in VALID
        do_fetch(6'd20, 16'h9A3C, 2);
        held_opc = exp_opc;
        flush = 1; tick(); flush = 0;
        n_tests++;
        if ({opcode_valid, imem_req, busy, opcode_out, imm_out} !== {3'b000, held_opc, exp_imm}) begin
            n_fail++;
            $display("FAIL flush_valid: vld=%b req=%b busy=%b opc=%h imm=%h want 0 0 0 %h %h", opcode_valid, imem_req, busy, opcode_out, imm_out, held_opc, exp_imm);
        end
        // flush in REQ; a following ack in IDLE is ignored
        fetch_start = 1; pc_in = 6'd33; tick(); fetch_start = 0;
        flush = 1; tick(); flush = 0;
        imem_ack = 1; imem_data = 16'h1234; tick(); tick(); imem_ack = 0;
        n_tests++;
        if ({opcode_valid, imem_req, busy, opcode_out} !== {3'b000, held_opc}) begin
            n_fail++;
            $display("FAIL flush_req: vld=%b req=%b busy=%b opc=%h want 0 0 0 %h", opcode_valid, imem_req, busy, opcode_out, held_opc);
        end
        // flush in DEC keeps old outputs
        fetch_start = 1; pc_in = 6'd34; tick(); fetch_start = 0;
        imem_ack = 1; imem_data = 16'hD123; tick(); imem_ack = 0;
        flush = 1; tick(); flush = 0;
        tick();
        n_tests++;
        if ({opcode_valid, busy, opcode_out} !== {2'b00, held_opc}) begin
            n_fail++;
            $display("FAIL flush_dec: vld=%b busy=%b opc=%h want 0 0 %h", opcode_valid, busy, opcode_out, held_opc);
        end
        // redirect: flush + fetch_start in REQ with a stale ack in the same cycle
        fetch_start = 1; pc_in = 6'd3; tick();
        flush = 1; pc_in = 6'd9; imem_ack = 1; imem_data = 16'hE777; tick();
        flush = 0; fetch_start = 0; imem_ack = 0;
        n_tests++;
        if ({imem_req, imem_addr, busy, opcode_valid} !== {1'b1, 6'd9, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL redirect: req=%b addr=%h busy=%b vld=%b want 1 09 1 0", imem_req, imem_addr, busy, opcode_valid);
        end
        tick(); tick();
        n_tests++;
        if ({imem_req, imem_addr, opcode_valid} !== {1'b1, 6'd9, 1'b0}) begin
            n_fail++;
            $display("FAIL redirect_stale: req=%b addr=%h vld=%b want 1 09 0", imem_req, imem_addr, opcode_valid);
        end
        imem_ack = 1; imem_data = 16'h5B81; tick(); imem_ack = 0; tick();
        exp_opc = model_opc(16'h5B81); exp_imm = 8'h81;
        n_tests++;
        if ({opcode_valid, opcode_out, imm_out} !== {1'b1, exp_opc, exp_imm}) begin
            n_fail++;
            $display("FAIL redirect_result: vld=%b opc=%h imm=%h want 1 %h %h", opcode_valid, opcode_out, imm_out, exp_opc, exp_imm);
        end
    endtask

    task automatic test_reset_mid_req();
        fetch_start = 1; pc_in = 6'd7; tick(); fetch_start = 0;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({imem_req, opcode_valid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async: req=%b vld=%b busy=%b want 0 0 0", imem_req, opcode_valid, busy);
        end
        #2 reset = 1'b0;
        exp_opc = 27'h0000001; exp_imm = 0; exp_err = 0;
        imem_ack = 1; imem_data = 16'h4600;
        tick(); tick(); tick();
        imem_ack = 0;
        n_tests++;
        if ({imem_req, opcode_valid, busy, opcode_out, imm_out, imem_addr} !== {3'b000, 27'h0000001, 8'h00, 6'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_req: req=%b vld=%b busy=%b opc=%h imm=%h addr=%h want 0 0 0 0000001 00 00", imem_req, opcode_valid, busy, opcode_out, imm_out, imem_addr);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        fetch_start = 1; pc_in = 6'd44; tick(); fetch_start = 0;
`ifdef IFD_TIMEOUT_EN
        cyc = 0;
        while (!opcode_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        exp_opc = 27'h0000001; exp_imm = 0; exp_err = 1;
        n_tests++;
        if (cyc != TO || {fetch_error, opcode_valid, imem_req, busy, opcode_out, imm_out} !== {4'b1100, 27'h0000001, 8'h00}) begin
            n_fail++;
            $display("FAIL timeout: cycles=%0d err=%b vld=%b req=%b busy=%b opc=%h imm=%h want %0d 1 1 0 0 0000001 00", cyc, fetch_error, opcode_valid, imem_req, busy, opcode_out, imm_out, TO);
        end
        do_fetch(6'd45, 16'h7C42, 2);
        n_tests++;
        if (fetch_error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: err=%b want 1", fetch_error);
        end
`else
        cyc = 0;
        repeat (40) begin tick(); cyc++; end
        n_tests++;
        if ({imem_req, busy, opcode_valid, fetch_error, imem_addr} !== {4'b1100, 6'd44}) begin
            n_fail++;
            $display("FAIL no_timeout after %0d: req=%b busy=%b vld=%b err=%b addr=%h want 1 1 0 0 2c", cyc, imem_req, busy, opcode_valid, fetch_error, imem_addr);
        end
        flush = 1; tick(); flush = 0;
        do_fetch(6'd45, 16'h7C42, 1);
`endif
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_sweep();
        test_random();
        test_ignore();
        test_flush();
        test_reset_mid_req();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
